// File: rtl/lsu_mem_unit.sv
// lsu_mem_unit: multi-cycle load/store unit bridging EXU requests to a split request/response data bus.
// Lane placement, extension, misalignment/illegal-op checks and a WAIT timeout, with a registered result to WBU.
module lsu_mem_unit #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [ADDR_W-1:0]     i_in_addr,
    input  logic                  i_in_wen,
    input  logic [2:0]            i_in_op,
    input  logic [XLEN-1:0]       i_in_wdata,
    output logic                  o_bus_req_valid,
    input  logic                  i_bus_req_ready,
    output logic [ADDR_W-1:0]     o_bus_addr,
    output logic                  o_bus_wen,
    output logic [DATA_W-1:0]     o_bus_wdata,
    output logic [DATA_W/8-1:0]   o_bus_wstrb,
    input  logic                  i_bus_resp_valid,
    output logic                  o_bus_resp_ready,
    input  logic [DATA_W-1:0]     i_bus_rdata,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [XLEN-1:0]       o_out_rdata,
    output logic [1:0]            o_out_err
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t             r_state, w_next;
    logic [ADDR_W-1:0]  r_bus_addr;
    logic [DATA_W-1:0]  r_bus_wdata;
    logic [STRB_W-1:0]  r_bus_wstrb;
    logic               r_wen;
    logic [2:0]         r_op;
    logic [OFF_W-1:0]   r_off;
    logic [CNT_W-1:0]   r_cnt;
    logic [XLEN-1:0]    r_rdata;
    logic [1:0]         r_err;

    logic               w_illegal, w_misal, w_timeout, w_sext;
    logic [2:0]         w_amask;
    logic [31:0]        w_lanes;
    logic [STRB_W-1:0]  w_strb;
    logic [DATA_W-1:0]  w_wdata, w_shift;
    logic [XLEN-1:0]    w_shx, w_load;

    assign w_illegal = (i_in_op == 3'd7) || (i_in_wen && i_in_op[2])
                     || ((DATA_W == 32) && (i_in_op == 3'd3 || i_in_op == 3'd6));
    // access size minus one doubles as the alignment mask on the low address bits
    assign w_amask   = 3'((4'd1 << i_in_op[1:0]) - 4'd1);
    assign w_misal   = |(i_in_addr[2:0] & w_amask);
    assign w_lanes   = (32'd1 << (32'd1 << i_in_op[1:0])) - 32'd1;
    assign w_strb    = STRB_W'(w_lanes << i_in_addr[OFF_W-1:0]);
    assign w_wdata   = DATA_W'(i_in_wdata) << {i_in_addr[OFF_W-1:0], 3'b000};
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));

    assign w_shift = i_bus_rdata >> {r_off, 3'b000};
    assign w_shx   = XLEN'(w_shift);
    assign w_sext  = ~r_op[2];
    assign w_load  = (r_op[1:0] == 2'd0) ? {{(XLEN-8){w_sext & w_shx[7]}}, w_shx[7:0]} :
                     (r_op[1:0] == 2'd1) ? {{(XLEN-16){w_sext & w_shx[15]}}, w_shx[15:0]} :
                     (r_op[1:0] == 2'd2) ? {{(XLEN-32){w_sext & w_shx[31]}}, w_shx[31:0]} : w_shx;

    assign o_in_ready       = (r_state == S_IDLE);
    assign o_bus_req_valid  = (r_state == S_REQ);
    assign o_bus_resp_ready = (r_state == S_WAIT);
    assign o_out_valid      = (r_state == S_RESP);
    assign o_bus_addr       = r_bus_addr;
    assign o_bus_wen        = r_wen;
    assign o_bus_wdata      = r_bus_wdata;
    assign o_bus_wstrb      = r_bus_wstrb;
    assign o_out_rdata      = r_rdata;
    assign o_out_err        = r_err;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_in_valid) w_next = (w_illegal || w_misal) ? S_RESP : S_REQ;
            S_REQ:   if (i_bus_req_ready) w_next = S_WAIT;
            S_WAIT:  if (i_bus_resp_valid || w_timeout) w_next = S_RESP;
            default: if (i_out_ready) w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
            r_wen       <= 1'b0;
            r_op        <= '0;
            r_off       <= '0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_err       <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_in_valid) begin
                    r_bus_addr  <= {i_in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    r_bus_wdata <= i_in_wen ? w_wdata : '0;
                    r_bus_wstrb <= i_in_wen ? w_strb : '0;
                    r_wen       <= i_in_wen;
                    r_op        <= i_in_op;
                    r_off       <= i_in_addr[OFF_W-1:0];
                    r_rdata     <= '0;
                    r_err       <= w_illegal ? 2'd3 : w_misal ? 2'd1 : 2'd0;
                end
                S_REQ: if (i_bus_req_ready) r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // a response in the timeout cycle still completes normally
                    if (i_bus_resp_valid) begin
                        r_rdata <= r_wen ? '0 : w_load;
                        r_err   <= 2'd0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_unit.sv
// tb_lsu_mem_unit: directed transactions against a transaction-level model of the LSU,
// with a per-cycle compare process and literal pins from hand-worked examples.
module tb_lsu_mem_unit;
    localparam int TO = 4;

    logic        clock = 0, reset_n = 0;
    logic        in_valid = 0, in_wen = 0, bus_req_ready = 0, bus_resp_valid = 0, out_ready = 0;
    logic [63:0] in_addr = 0, in_wdata = 0, bus_rdata = 0;
    logic [2:0]  in_op = 0;
    logic        in_ready, bus_req_valid, bus_wen, bus_resp_ready, out_valid;
    logic [63:0] bus_addr, bus_wdata, out_rdata;
    logic [7:0]  bus_wstrb;
    logic [1:0]  out_err;

    logic        in_valid2 = 0, out_ready2 = 0;
    logic        in_ready2, bus_req_valid2, bus_wen2, bus_resp_ready2, out_valid2;
    logic [63:0] bus_addr2, out_rdata2;
    logic [31:0] bus_wdata2;
    logic [3:0]  bus_wstrb2;
    logic [1:0]  out_err2;

    int n_cmp = 0, n_bad = 0;
    bit m_req = 0, m_wait = 0, m_out = 0;
    logic [63:0] e_addr, e_wdata, e_rdata;
    logic [7:0]  e_strb;
    logic        e_wen;
    logic [1:0]  e_err;
    logic [63:0] last_baddr, last_wdata, last_rdata;
    logic [7:0]  last_strb;
    logic [1:0]  last_err;

    always #5 clock = ~clock;

    lsu_mem_unit #(.ADDR_W(64), .DATA_W(64), .XLEN(64), .TIMEOUT(TO)) dut (
        .i_clock(clock), .i_reset(reset_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_addr(in_addr), .i_in_wen(in_wen),
        .i_in_op(in_op), .i_in_wdata(in_wdata),
        .o_bus_req_valid(bus_req_valid), .i_bus_req_ready(bus_req_ready), .o_bus_addr(bus_addr),
        .o_bus_wen(bus_wen), .o_bus_wdata(bus_wdata), .o_bus_wstrb(bus_wstrb),
        .i_bus_resp_valid(bus_resp_valid), .o_bus_resp_ready(bus_resp_ready), .i_bus_rdata(bus_rdata),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_rdata(out_rdata), .o_out_err(out_err));

    lsu_mem_unit #(.ADDR_W(64), .DATA_W(32), .XLEN(64), .TIMEOUT(TO)) dut32 (
        .i_clock(clock), .i_reset(reset_n),
        .i_in_valid(in_valid2), .o_in_ready(in_ready2), .i_in_addr(in_addr), .i_in_wen(in_wen),
        .i_in_op(in_op), .i_in_wdata(in_wdata),
        .o_bus_req_valid(bus_req_valid2), .i_bus_req_ready(bus_req_ready), .o_bus_addr(bus_addr2),
        .o_bus_wen(bus_wen2), .o_bus_wdata(bus_wdata2), .o_bus_wstrb(bus_wstrb2),
        .i_bus_resp_valid(bus_resp_valid), .o_bus_resp_ready(bus_resp_ready2), .i_bus_rdata(bus_rdata[31:0]),
        .o_out_valid(out_valid2), .i_out_ready(out_ready2), .o_out_rdata(out_rdata2), .o_out_err(out_err2));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Spec-level result of one access: error class, extended load value, lanes and shifted store data.
    function automatic void model(input logic [63:0] a, input bit w, input logic [2:0] op,
                                  input logic [63:0] wd, input logic [63:0] rd,
                                  output logic [1:0] err, output logic [63:0] res,
                                  output logic [7:0] strb, output logic [63:0] bwd);
        int n = 1 << op[1:0];
        int off = int'(a % 8);
        logic [63:0] v, mask;
        strb = w ? 8'(((1 << n) - 1) << off) : 8'd0;
        bwd  = w ? wd << (8 * off) : 64'd0;
        err = 0;
        res = 0;
        if (op == 7 || (w && op >= 4)) err = 3;
        else if (a % n != 0) err = 1;
        else if (!w) begin
            v = rd >> (8 * off);
            if (n < 8) begin
                mask = (64'd1 << (8 * n)) - 64'd1;
                v &= mask;
                if (op < 3 && v[8*n-1]) v |= ~mask;
            end
            res = v;
        end
    endfunction

    always @(negedge clock) begin
        chk("in_ready", in_ready, !(m_req || m_wait || m_out));
        chk("req_valid", bus_req_valid, m_req);
        chk("resp_ready", bus_resp_ready, m_wait);
        chk("out_valid", out_valid, m_out);
        chk("dw32_req_valid", bus_req_valid2, 0);
        if (m_req) begin
            chk("bus_addr", bus_addr, e_addr);
            chk("bus_wen", bus_wen, e_wen);
            chk("bus_wdata", bus_wdata, e_wdata);
            chk("bus_wstrb", bus_wstrb, e_strb);
            last_baddr = bus_addr; last_wdata = bus_wdata; last_strb = bus_wstrb;
        end
        if (m_out) begin
            chk("out_rdata", out_rdata, e_rdata);
            chk("out_err", out_err, e_err);
            last_rdata = out_rdata; last_err = out_err;
        end
    end

    task automatic txn(input logic [63:0] a, input bit w, input logic [2:0] op, input logic [63:0] wd,
                       input logic [63:0] rd, input int req_wait, input int resp_wait, input int out_wait);
        logic [1:0] er;
        logic [63:0] rs;
        int k = 0;
        model(a, w, op, wd, rd, er, rs, e_strb, e_wdata);
        e_addr = a & ~64'h7; e_wen = w;
        last_baddr = 'x; last_wdata = 'x; last_strb = 'x; last_rdata = 'x; last_err = 'x;
        in_valid = 1; in_addr = a; in_wen = w; in_op = op; in_wdata = wd;
        @(posedge clock); #1;
        in_valid = 0; in_addr = {$urandom, $urandom}; in_wen = ~w; in_op = 3'($urandom); in_wdata = {$urandom, $urandom};
        if (er == 0) begin
            m_req = 1;
            bus_resp_valid = (req_wait > 0); bus_rdata = {$urandom, $urandom};
            repeat (req_wait) begin @(posedge clock); #1; end
            bus_resp_valid = 0; bus_req_ready = 1;
            @(posedge clock); #1;
            bus_req_ready = 0; m_req = 0; m_wait = 1;
            forever begin
                if (k == resp_wait) begin bus_resp_valid = 1; bus_rdata = rd; end
                @(posedge clock); #1;
                bus_resp_valid = 0; bus_rdata = {$urandom, $urandom};
                if (k == resp_wait || k == TO) break;
                k++;
            end
            if (resp_wait > TO) begin er = 2; rs = 0; end
            m_wait = 0;
        end
        e_err = er; e_rdata = rs; m_out = 1;
        repeat (out_wait) begin @(posedge clock); #1; end
        out_ready = 1;
        @(posedge clock); #1;
        out_ready = 0; m_out = 0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_out_rdata", out_rdata, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_bus_wstrb", bus_wstrb, 0);
        reset_n = 1;
        @(posedge clock); #1;

        txn(64'h8000_0003, 0, 3'd0, 0, 64'h0000_0000_8000_0000, 0, 0, 0);
        chk("lb_addr", last_baddr, 64'h8000_0000);
        chk("lb_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_err", last_err, 0);
        txn(64'h8000_0003, 0, 3'd4, 0, 64'h0000_0000_8000_0000, 0, 0, 0);
        chk("lbu_rdata", last_rdata, 64'h80);
        txn(64'h8000_0006, 1, 3'd1, 64'h1234, 0, 0, 1, 0);
        chk("sh_strb", last_strb, 8'hC0);
        chk("sh_wdata", last_wdata, 64'h1234_0000_0000_0000);
        chk("sh_rdata", last_rdata, 0);
        txn(64'h8000_0002, 0, 3'd2, 0, 0, 0, 0, 0);
        chk("lw_mis_err", last_err, 1);
        txn(64'h8000_0004, 1, 3'd2, 64'hDEAD_BEEF, 0, 5, 0, 3);
        chk("sw_strb", last_strb, 8'hF0);
        chk("sw_wdata", last_wdata, 64'hDEAD_BEEF_0000_0000);
        txn(64'h8000_0010, 0, 3'd3, 0, 64'h8877_6655_4433_2211, 0, 2, 0);
        chk("ld_rdata", last_rdata, 64'h8877_6655_4433_2211);
        txn(64'h8000_0002, 0, 3'd1, 0, 64'h0000_0000_8001_0000, 1, 0, 1);
        chk("lh_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_8001);
        txn(64'h8000_0002, 0, 3'd5, 0, 64'h0000_0000_8001_0000, 0, 0, 0);
        chk("lhu_rdata", last_rdata, 64'h8001);
        txn(64'h8000_0004, 0, 3'd2, 0, 64'h8000_0000_0000_0000, 0, 0, 0);
        chk("lw_rdata", last_rdata, 64'hFFFF_FFFF_8000_0000);
        txn(64'h8000_0004, 0, 3'd6, 0, 64'h8000_0000_0000_0000, 0, 0, 0);
        chk("lwu_rdata", last_rdata, 64'h8000_0000);
        txn(64'h8000_0008, 0, 3'd2, 0, 64'h1, 0, TO + 1, 0);
        chk("timeout_err", last_err, 2);
        txn(64'h8000_0000, 0, 3'd2, 0, 64'h1122_3344_5566_7788, 0, TO, 0);
        chk("tie_err", last_err, 0);
        chk("tie_rdata", last_rdata, 64'h5566_7788);
        txn(64'h8000_0000, 1, 3'd4, 64'hFF, 0, 0, 0, 0);
        chk("sbu_illegal", last_err, 3);
        txn(64'h8000_0000, 0, 3'd7, 0, 0, 0, 0, 1);
        chk("op7_illegal", last_err, 3);
        txn(64'h8000_0004, 0, 3'd3, 0, 0, 0, 0, 0);
        chk("ld_mis", last_err, 1);
        txn(64'h8000_0001, 1, 3'd1, 64'h55, 0, 0, 0, 0);
        chk("sh_mis", last_err, 1);

        model(64'h8000_0018, 1, 3'd3, 64'hCAFE, 0, e_err, e_rdata, e_strb, e_wdata);
        e_addr = 64'h8000_0018; e_wen = 1;
        in_valid = 1; in_addr = 64'h8000_0018; in_wen = 1; in_op = 3'd3; in_wdata = 64'hCAFE;
        @(posedge clock); #1;
        in_valid = 0; m_req = 1; bus_req_ready = 1;
        @(posedge clock); #1;
        bus_req_ready = 0; m_req = 0; m_wait = 1;
        @(posedge clock); #1;
        reset_n = 0; m_wait = 0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_req_valid", bus_req_valid, 0);
        chk("abort_resp_ready", bus_resp_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_bus_addr", bus_addr, 0);
        chk("abort_bus_wen", bus_wen, 0);
        chk("abort_bus_wdata", bus_wdata, 0);
        chk("abort_bus_wstrb", bus_wstrb, 0);
        @(posedge clock); #1;
        reset_n = 1;
        @(posedge clock); #1;
        txn(64'h8000_0020, 0, 3'd2, 0, 64'h0000_0000_7FFF_FFFF, 0, 1, 0);
        chk("post_abort_lw", last_rdata, 64'h7FFF_FFFF);

        for (int i = 0; i < 2; i++) begin
            in_valid2 = 1; in_addr = 64'h8000_0000; in_wen = 0; in_op = (i == 0) ? 3'd3 : 3'd6;
            @(posedge clock); #1;
            in_valid2 = 0; out_ready2 = 1;
            chk("dw32_out_valid", out_valid2, 1);
            chk("dw32_err", out_err2, 3);
            chk("dw32_rdata", out_rdata2, 0);
            @(posedge clock); #1;
            out_ready2 = 0;
            chk("dw32_idle", {out_valid2, in_ready2}, 2'b01);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
